line_buffer_3row: RTL and testbench
===================================

// Module: line_buffer_3row
// PURPOSE
//  Raster-to-window front end for the convolution stage. Accepts one pixel per clock
//  with dv/hs/vs timing. Buffers the previous M_DEPTH-1 lines in on-chip line RAMs.
//  Each valid clock, emits an M_DEPTH-tall pixel column (current row plus rows above).
//  Outputs feed the convolution's vect_in/dv_i/hs_i/vs_i directly.
// PARAMETERS
//  COLORDEPTH   8     bits per pixel
//  SCREENWIDTH  1600  nominal active pixels per line (bench/doc only; no logic depends on it)
//  LINE_END     2048  line RAM depth; max pixels stored per line
//  M_DEPTH      3     output column height (rows); M_DEPTH-1 line RAMs
// PORTS
//  clk            in   1                 clock
//  rst            in   1                 reset, synchronous, active-high
//  pix_i          in   COLORDEPTH        input pixel, sampled when dv_i=1
//  dv_i           in   1                 data valid
//  hs_i           in   1                 hsync (delayed only)
//  vs_i           in   1                 vsync; low = blanking, clears frame state
//  vect_o         out  COLORDEPTH x M_DEPTH  [0]=current row, [k]=k lines above
//  dv_o/hs_o/vs_o out  1                 dv_i/hs_i/vs_i delayed by LATENCY
//  rows_valid_o   out  1                 1 when M_DEPTH-1 full lines are stored this frame
//  overflow_o     out  1                 sticky: a line exceeded LINE_END pixels
// BEHAVIOUR
//  - Reset: every output 0, col/line counters 0, overflow_o cleared. RAM contents are not
//    cleared; stale data is masked by the line counter.
//  - LATENCY = 3 clocks, fixed, for all outputs.
//    Pipeline, from input sampled at edge n:
//      edge n+1: input register
//      edge n+2: RAM read-data stage
//      edge n+3: output register; result visible after edge n+3
//  - col (addr width $clog2(LINE_END)):
//      increments on each registered dv=1 cycle;
//      returns to 0 on the first registered dv=0 cycle;
//      saturates at LINE_END-1.
//  - Pixels beyond LINE_END in one line: not written to RAM; col holds; overflow_o<=1.
//    Pixel still passes on vect_o[0]; overflow_o stays set until rst.
//  - line_cnt (0..M_DEPTH-1):
//      +1 on each dv falling edge (registered);
//      saturates at M_DEPTH-1;
//      forced to 0 on any cycle with vs_i=0 or rst.
//  - RAM k (k=0..M_DEPTH-2) is simple dual-port, read-first, 1-clk read latency.
//      RAM0 writes the pixel at col.
//      RAM k>0 writes RAM k-1's read data at col delayed 1 clk. The delayed write never
//      collides with the next read of that address (one line later).
//  - Read of RAM k at col yields the pixel k+1 lines above. vect_o[k+1] = that data.
//  - Zero padding: vect_o[k]=0 for k>line_cnt, so the first lines of a frame see 0 above.
//  - rows_valid_o = (line_cnt==M_DEPTH-1), aligned to output timing.
//  - When the registered dv=0, vect_o holds 0.
//  - Simultaneous dv fall and vs fall: vs wins; line_cnt=0.
//  - rst mid-line: pipeline flushes to 0. The next line is treated as line 0 of a frame.
// STRUCTURE
//  - Shared package img_pkg: COLORDEPTH, LINE_END; typedef pixel_t = logic [COLORDEPTH-1:0];
//    typedef addr_t = logic [$clog2(LINE_END)-1:0]; localparam LB_LATENCY = 3.
//    The convolution stage imports the same pixel_t.
//  - Sub-module line_ram:
//      parameters: depth LINE_END, width COLORDEPTH;
//      ports: wa, wd, we, ra, rd;
//      read-first, registered output; instantiated M_DEPTH-1 times via generate.
//  - Top: input register, counters, RAM cascade, masking, sync delay shift register.
// TESTING
//  1 rst held 2 clk during active traffic -> all outputs 0 next clk; overflow_o=0.
//  2 LINE_END=16, vs=1, 3 lines of 8 px (line L px c = 10*L+c+1, 2 blank clk between) ->
//    line0: vect_o={0,0,1..8}.
//    line1: vect_o={0,1,11}..{0,8,18}.
//    line2: vect_o[2:0]={1,11,21}..{8,18,28}; rows_valid_o=1 only during line2.
//  3 single dv pulse at clk n with hs/vs patterns -> dv_o/hs_o/vs_o identical, shifted
//    exactly 3 clk.
//  4 frame A (3 lines), vs low 4 clk, frame B line0 -> vect_o[1],[2]=0 despite RAM data;
//    rows_valid_o=0.
//  5 LINE_END=16, one line of 18 px ->
//    overflow_o=1 from px 17 on;
//    next line vect_o[1] cols 0..15 match, no wrap corruption;
//    overflow_o stays 1 until rst.
//  6 dv falls on the same clk vs falls -> line_cnt 0; next frame starts zero-padded.

Source files
------------

// File: rtl/img_pkg.sv
// Shared image-pipeline types: pixel and line-address widths, sync bundle.
package img_pkg;

  localparam int COLORDEPTH = 8;
  localparam int LINE_END   = 2048;
  localparam int ADDR_W     = $clog2(LINE_END);
  localparam int LB_LATENCY = 3;

  typedef logic [COLORDEPTH-1:0] pixel_t;
  typedef logic [ADDR_W-1:0]     addr_t;

  // Video timing strobes that travel alongside pixel data
  typedef struct packed {
    logic dv;
    logic hs;
    logic vs;
  } sync_t;

endpackage

// File: rtl/line_buffer_3row_line_ram.sv
// Simple dual-port line RAM: read-first, one-clock registered read data.
module line_ram #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] wa,
  input  logic [WIDTH-1:0]         wd,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] ra,
  output logic [WIDTH-1:0]         rd
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_d;
  logic [WIDTH-1:0] rd_q;

  // Read the old contents of the addressed word (read-first on same-address write)
  always_comb begin
    rd_d = mem_q[ra];
  end

  // Storage write and read-data register
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wa] <= wd;
    end
    rd_q <= rd_d;
  end

  assign rd = rd_q;

endmodule

// File: rtl/line_buffer_3row.sv
// Raster-to-window front end: turns a pixel stream into an M_DEPTH-tall column
// (current row plus rows above) with a fixed three-clock latency.
module line_buffer_3row #(
  parameter int COLORDEPTH = img_pkg::COLORDEPTH,
  parameter int LINE_END   = img_pkg::LINE_END,
  parameter int M_DEPTH    = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [COLORDEPTH-1:0]         pix_i,
  input  logic                          dv_i,
  input  logic                          hs_i,
  input  logic                          vs_i,
  output logic [COLORDEPTH*M_DEPTH-1:0] vect_o,
  output logic                          dv_o,
  output logic                          hs_o,
  output logic                          vs_o,
  output logic                          rows_valid_o,
  output logic                          overflow_o
);

  import img_pkg::*;

  localparam int AW = $clog2(LINE_END);
  localparam int CW = $clog2(M_DEPTH);
  localparam logic [AW-1:0] COL_LAST = AW'(LINE_END - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(M_DEPTH - 1);

  // Input register stage
  sync_t                 sync_p1_d, sync_p1_q;
  logic [COLORDEPTH-1:0] pix_p1_d, pix_p1_q;
  logic [AW-1:0]         col_d, col_q;
  logic                  full_d, full_q;
  logic [CW-1:0]         line_cnt_d, line_cnt_q;
  logic                  skip_d, skip_q;
  logic                  we0;

  // RAM read-data stage
  sync_t                 sync_p2_d, sync_p2_q;
  logic [COLORDEPTH-1:0] pix_p2_d, pix_p2_q;
  logic [AW-1:0]         col_p2_d, col_p2_q;
  logic                  we_p2_d, we_p2_q;
  logic                  ovf_p2_d, ovf_p2_q;
  logic [CW-1:0]         cnt_p2_d, cnt_p2_q;

  // Output register stage
  sync_t                         sync_o_d, sync_o_q;
  logic [COLORDEPTH*M_DEPTH-1:0] vect_d, vect_q;
  logic                          rv_d, rv_q;
  logic                          overflow_d, overflow_q;

  logic [COLORDEPTH-1:0] ram_rd [M_DEPTH-1];

  // Pixels past the end of the line RAM still flow through but are never stored
  assign we0 = sync_p1_q.dv && !full_q;

  // Input register: capture stream, track column and line position in frame
  always_comb begin
    sync_p1_d = '{dv: dv_i, hs: hs_i, vs: vs_i};
    pix_p1_d  = pix_i;
    if (sync_p1_q.dv) begin
      col_d = (col_q == COL_LAST) ? col_q : col_q + AW'(1);
    end else begin
      col_d = '0;
    end
    full_d     = sync_p1_q.dv && (full_q || (col_q == COL_LAST));
    line_cnt_d = line_cnt_q;
    if (!vs_i) begin
      line_cnt_d = '0;
    end else if (sync_p1_q.dv && !dv_i && !skip_q && (line_cnt_q != CNT_MAX)) begin
      line_cnt_d = line_cnt_q + CW'(1);
    end
    // A line cut by reset must not count, so its end is skipped once
    skip_d = skip_q && dv_i;
    if (rst) begin
      sync_p1_d  = '0;
      col_d      = '0;
      full_d     = 1'b0;
      line_cnt_d = '0;
      skip_d     = dv_i;
    end
  end

  // RAM read-data stage: carry pixel and control alongside the RAM read
  always_comb begin
    sync_p2_d = sync_p1_q;
    pix_p2_d  = pix_p1_q;
    col_p2_d  = col_q;
    we_p2_d   = we0;
    ovf_p2_d  = sync_p1_q.dv && full_q;
    cnt_p2_d  = line_cnt_q;
    if (rst) begin
      sync_p2_d = '0;
      we_p2_d   = 1'b0;
      ovf_p2_d  = 1'b0;
      cnt_p2_d  = '0;
    end
  end

  // Output register: zero-pad rows not yet filled this frame, blank when invalid
  always_comb begin
    sync_o_d   = sync_p2_q;
    rv_d       = (cnt_p2_q == CNT_MAX);
    overflow_d = overflow_q || ovf_p2_q;
    vect_d     = '0;
    if (sync_p2_q.dv) begin
      vect_d[COLORDEPTH-1:0] = pix_p2_q;
      for (int k = 1; k < M_DEPTH; k++) begin
        if (k <= int'(cnt_p2_q)) begin
          vect_d[k*COLORDEPTH +: COLORDEPTH] = ram_rd[k-1];
        end
      end
    end
    if (rst) begin
      sync_o_d   = '0;
      rv_d       = 1'b0;
      overflow_d = 1'b0;
      vect_d     = '0;
    end
  end

  // Pipeline registers
  always_ff @(posedge clk) begin
    sync_p1_q  <= sync_p1_d;
    pix_p1_q   <= pix_p1_d;
    col_q      <= col_d;
    full_q     <= full_d;
    line_cnt_q <= line_cnt_d;
    skip_q     <= skip_d;
    sync_p2_q  <= sync_p2_d;
    pix_p2_q   <= pix_p2_d;
    col_p2_q   <= col_p2_d;
    we_p2_q    <= we_p2_d;
    ovf_p2_q   <= ovf_p2_d;
    cnt_p2_q   <= cnt_p2_d;
    sync_o_q   <= sync_o_d;
    vect_q     <= vect_d;
    rv_q       <= rv_d;
    overflow_q <= overflow_d;
  end

  // RAM cascade: RAM0 stores the live line; each later RAM takes its
  // predecessor's read data one clock later, shifting a line per line time.
  for (genvar k = 0; k < M_DEPTH - 1; k++) begin : g_ram
    logic [AW-1:0]         ram_wa;
    logic [COLORDEPTH-1:0] ram_wd;
    logic                  ram_we;
    if (k == 0) begin : g_head
      assign ram_wa = col_q;
      assign ram_wd = pix_p1_q;
      assign ram_we = we0;
    end else begin : g_tail
      assign ram_wa = col_p2_q;
      assign ram_wd = ram_rd[k-1];
      assign ram_we = we_p2_q;
    end
    line_ram #(
      .DEPTH(LINE_END),
      .WIDTH(COLORDEPTH)
    ) u_ram (
      .clk(clk),
      .wa (ram_wa),
      .wd (ram_wd),
      .we (ram_we),
      .ra (col_q),
      .rd (ram_rd[k])
    );
  end

  assign vect_o       = vect_q;
  assign dv_o         = sync_o_q.dv;
  assign hs_o         = sync_o_q.hs;
  assign vs_o         = sync_o_q.vs;
  assign rows_valid_o = rv_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Directed bench for line_buffer_3row with a 16-pixel line RAM.
module tb_line_buffer_3row;

  localparam int CD = 8;
  localparam int LE = 16;
  localparam int MD = 3;

  localparam logic [3:0] M_VECT = 4'b0001;
  localparam logic [3:0] M_SYNC = 4'b0010;
  localparam logic [3:0] M_RV   = 4'b0100;
  localparam logic [3:0] M_OVF  = 4'b1000;
  localparam logic [3:0] M_ALL  = 4'b1111;

  logic             clk = 1'b0;
  logic             rst;
  logic [CD-1:0]    pix_i;
  logic             dv_i, hs_i, vs_i;
  logic [CD*MD-1:0] vect_o;
  logic             dv_o, hs_o, vs_o, rows_valid_o, overflow_o;

  always #5 clk = ~clk;

  line_buffer_3row #(.COLORDEPTH(CD), .LINE_END(LE), .M_DEPTH(MD)) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_i       (pix_i),
    .dv_i        (dv_i),
    .hs_i        (hs_i),
    .vs_i        (vs_i),
    .vect_o      (vect_o),
    .dv_o        (dv_o),
    .hs_o        (hs_o),
    .vs_o        (vs_o),
    .rows_valid_o(rows_valid_o),
    .overflow_o  (overflow_o)
  );

  typedef struct {
    logic [23:0] vect;
    logic        dv, hs, vs, rv, ovf;
    logic [3:0]  mask;
    string       tag;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_ovf = 1'b0;

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] v3(input int a2, input int a1, input int a0);
    return {8'(a2), 8'(a1), 8'(a0)};
  endfunction

  task automatic push_zero(input string tag);
    exp_t e;
    e.vect = '0; e.dv = 0; e.hs = 0; e.vs = 0; e.rv = 0; e.ovf = 0;
    e.mask = M_ALL; e.tag = tag;
    expq.push_back(e);
  endtask

  // Drive one clock of input; compare the output that is now due (3 clocks old)
  task automatic step(input logic dv, input logic hs, input logic vs, input int pix,
                      input logic [23:0] ev, input logic erv, input logic [3:0] mask,
                      input string tag);
    exp_t e, o;
    dv_i = dv; hs_i = hs; vs_i = vs; pix_i = 8'(pix);
    e.vect = ev; e.dv = dv; e.hs = hs; e.vs = vs; e.rv = erv; e.ovf = exp_ovf;
    e.mask = mask; e.tag = tag;
    expq.push_back(e);
    tick();
    if (expq.size() == 3) begin
      o = expq.pop_front();
      if (o.mask[0]) chk({o.tag, ".vect"}, vect_o, o.vect);
      if (o.mask[1]) chk({o.tag, ".sync"}, 24'({dv_o, hs_o, vs_o}), 24'({o.dv, o.hs, o.vs}));
      if (o.mask[2]) chk({o.tag, ".rows_valid"}, 24'(rows_valid_o), 24'(o.rv));
      if (o.mask[3]) chk({o.tag, ".overflow"}, 24'(overflow_o), 24'(o.ovf));
    end
  endtask

  task automatic blank(input int n, input logic vs, input logic erv, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, vs, 0, '0, erv, M_ALL, tag);
  endtask

  // One line of n pixels b0+c; rows above expected b1+c / b2+c, or 0 when negative
  task automatic line(input int n, input int b0, input int b1, input int b2,
                      input logic erv, input string tag);
    for (int c = 0; c < n; c++) begin
      step(1'b1, 1'b0, 1'b1, b0 + c,
           v3((b2 < 0) ? 0 : b2 + c, (b1 < 0) ? 0 : b1 + c, b0 + c),
           erv, M_ALL, $sformatf("%s.c%0d", tag, c));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".vect"}, vect_o, '0);
    chk({tag, ".sync"}, 24'({dv_o, hs_o, vs_o}), '0);
    chk({tag, ".rows_valid"}, 24'(rows_valid_o), '0);
    chk({tag, ".overflow"}, 24'(overflow_o), '0);
  endtask

  initial begin
    rst = 1'b1; dv_i = 0; hs_i = 0; vs_i = 0; pix_i = '0;
    tick();
    tick();
    chk_all_zero("init_rst");
    rst = 1'b0;
    push_zero("post_init0");
    push_zero("post_init1");

    // Reset held two clocks in the middle of a line
    blank(2, 1'b0, 1'b0, "idle");
    blank(1, 1'b1, 1'b0, "vs_rise");
    line(5, 90, -1, -1, 1'b0, "pre_rst");
    rst = 1'b1; dv_i = 1'b1; hs_i = 1'b0; vs_i = 1'b1; pix_i = 8'd95;
    tick();
    chk_all_zero("mid_rst1");
    tick();
    chk_all_zero("mid_rst2");
    rst = 1'b0;
    expq.delete();
    push_zero("post_rst0");
    push_zero("post_rst1");
    line(3, 95, -1, -1, 1'b0, "rst_resume");
    blank(2, 1'b1, 1'b0, "rst_resume_blank");

    // Three lines of eight pixels fill the window row by row
    line(8, 1, -1, -1, 1'b0, "l0");
    blank(2, 1'b1, 1'b0, "l0_blank");
    line(8, 11, 1, -1, 1'b0, "l1");
    blank(2, 1'b1, 1'b1, "l1_blank");
    line(8, 21, 11, 1, 1'b1, "l2");
    blank(2, 1'b1, 1'b1, "l2_blank");

    // vsync blanking clears frame state; stale RAM rows are masked
    blank(4, 1'b0, 1'b0, "vs_low");
    blank(1, 1'b1, 1'b0, "fb_start");
    line(8, 100, -1, -1, 1'b0, "fb_l0");
    blank(2, 1'b1, 1'b0, "fb_blank");

    // Sync strobes are delayed unchanged by three clocks
    step(1'b0, 1'b1, 1'b1, 0, '0, 1'b0, M_SYNC | M_VECT | M_OVF, "sy0");
    step(1'b0, 1'b0, 1'b1, 0, '0, 1'b0, M_SYNC | M_VECT | M_OVF, "sy1");
    step(1'b1, 1'b1, 1'b1, 77, '0, 1'b0, M_SYNC | M_OVF, "sy2");
    step(1'b0, 1'b1, 1'b0, 0, '0, 1'b0, M_SYNC | M_VECT | M_OVF, "sy3");
    step(1'b0, 1'b0, 1'b0, 0, '0, 1'b0, M_SYNC | M_VECT | M_OVF, "sy4");
    step(1'b0, 1'b1, 1'b1, 0, '0, 1'b0, M_SYNC | M_VECT | M_OVF, "sy5");
    step(1'b0, 1'b0, 1'b1, 0, '0, 1'b0, M_SYNC | M_VECT | M_OVF, "sy6");

    // 18-pixel line into a 16-deep RAM, then a normal line reading it back
    blank(2, 1'b0, 1'b0, "ov_vs_low");
    blank(1, 1'b1, 1'b0, "ov_start");
    for (int c = 0; c < 18; c++) begin
      if (c == 16) exp_ovf = 1'b1;
      step(1'b1, 1'b0, 1'b1, 50 + c, v3(0, 0, 50 + c), 1'b0, M_ALL,
           $sformatf("ov_l0.c%0d", c));
    end
    blank(2, 1'b1, 1'b0, "ov_blank0");
    line(16, 150, 50, -1, 1'b0, "ov_l1");
    blank(2, 1'b1, 1'b1, "ov_blank1");

    // dv and vs fall together: vs wins and the next frame is zero-padded
    blank(2, 1'b0, 1'b0, "dvvs_vs_low");
    blank(1, 1'b1, 1'b0, "dvvs_start");
    line(4, 200, -1, -1, 1'b0, "dvvs_a0");
    blank(2, 1'b1, 1'b0, "dvvs_a0_blank");
    line(4, 210, 200, -1, 1'b0, "dvvs_a1");
    step(1'b0, 1'b0, 1'b0, 0, '0, 1'b0, M_ALL, "dvvs_fall");
    blank(2, 1'b1, 1'b0, "dvvs_b_start");
    line(4, 220, -1, -1, 1'b0, "dvvs_b0");
    blank(2, 1'b1, 1'b0, "dvvs_tail");

    // Reset clears the sticky overflow flag
    rst = 1'b1; dv_i = 1'b0; vs_i = 1'b1;
    tick();
    chk_all_zero("final_rst");
    rst = 1'b0;
    exp_ovf = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
